// File: rtl/mem_ops_pkg.sv
// Shared definitions for the memory-stage controller: op-codes, FSM state
// encoding, default widths and a small op-classification helper.
package mem_ops_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 11;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDM  = 3'd1;
    localparam logic [2:0] OP_LDD  = 3'd2;
    localparam logic [2:0] OP_STD  = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_POP  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // True for ops whose result goes back to write-back after a memory read.
    function automatic logic is_load_op(input logic [2:0] code);
        logic result;
        case (code)
            OP_LDD:  result = 1'b1;
            OP_POP:  result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_sp_unit.sv
// Stack pointer register with post-decrement (PUSH) / pre-increment (POP)
// update and full/empty flags used by the optional stack check.
import mem_ops_pkg::*;

module sp_unit #(
    parameter int              ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] SP_INIT = 11'h7FF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_done,
    input  logic              pop_done,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_plus1,
    output logic              at_bottom,
    output logic              at_top
);

    localparam logic [ADDR_W-1:0] ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO = {ADDR_W{1'b0}};

    logic [ADDR_W-1:0] sp_r;

    // Stack pointer moves only when a PUSH/POP access is acknowledged; wraps modulo 2^ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_r <= SP_INIT;
        end else if (push_done) begin
            sp_r <= sp_r - ONE;
        end else if (pop_done) begin
            sp_r <= sp_r + ONE;
        end else begin
            sp_r <= sp_r;
        end
    end

    assign sp        = sp_r;
    assign sp_plus1  = sp_r + ONE;
    assign at_bottom = (sp_r == ZERO);
    assign at_top    = (sp_r == SP_INIT);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: accepts one memory op at a time, runs the
// data-memory req/ack handshake and returns load/immediate results.
// Optional feature macro: STACK_CHECK_EN (reject PUSH on full / POP on empty stack).
import mem_ops_pkg::*;

module mem_stage_ctrl #(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] SP_INIT = 11'h7FF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_exc
);

    state_t            state_r, state_n;
    logic [2:0]        op_r, op_n;
    logic              req_r, req_n;
    logic              we_r, we_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [DATA_W-1:0] wdata_r, wdata_n;
    logic              res_valid_r, res_valid_n;
    logic [DATA_W-1:0] res_data_r, res_data_n;
    logic              exc_r, exc_n;
    logic              push_done_s, pop_done_s;
    logic [ADDR_W-1:0] sp_s, sp_plus1_s;
    logic              at_bottom_s, at_top_s;
    logic              reject_push_s, reject_pop_s;

    sp_unit #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk       (clk),
        .rst       (rst),
        .push_done (push_done_s),
        .pop_done  (pop_done_s),
        .sp        (sp_s),
        .sp_plus1  (sp_plus1_s),
        .at_bottom (at_bottom_s),
        .at_top    (at_top_s)
    );

`ifdef STACK_CHECK_EN
    assign reject_push_s = at_bottom_s;
    assign reject_pop_s  = at_top_s;
`else
    // Without the check the stack simply wraps; the flags have no consumer.
    logic unused_stack_flags;
    assign unused_stack_flags = at_bottom_s & at_top_s;
    assign reject_push_s = 1'b0;
    assign reject_pop_s  = 1'b0;
`endif

    // Next-state and next-output decode; every registered output gets a default first.
    always_comb begin
        state_n     = state_r;
        op_n        = op_r;
        req_n       = req_r;
        we_n        = we_r;
        addr_n      = addr_r;
        wdata_n     = wdata_r;
        res_valid_n = 1'b0;
        res_data_n  = res_data_r;
        exc_n       = 1'b0;
        push_done_s = 1'b0;
        pop_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    op_n = op_code;
                    case (op_code)
                        OP_LDM: begin
                            state_n     = ST_DONE;
                            res_valid_n = 1'b1;
                            res_data_n  = op_data;
                        end
                        OP_LDD: begin
                            state_n = ST_ACCESS;
                            req_n   = 1'b1;
                            we_n    = 1'b0;
                            addr_n  = op_addr;
                        end
                        OP_STD: begin
                            state_n = ST_ACCESS;
                            req_n   = 1'b1;
                            we_n    = 1'b1;
                            addr_n  = op_addr;
                            wdata_n = op_data;
                        end
                        OP_PUSH: begin
                            if (reject_push_s) begin
                                state_n = ST_DONE;
                                exc_n   = 1'b1;
                            end else begin
                                state_n = ST_ACCESS;
                                req_n   = 1'b1;
                                we_n    = 1'b1;
                                addr_n  = sp_s;
                                wdata_n = op_data;
                            end
                        end
                        OP_POP: begin
                            if (reject_pop_s) begin
                                state_n = ST_DONE;
                                exc_n   = 1'b1;
                            end else begin
                                state_n = ST_ACCESS;
                                req_n   = 1'b1;
                                we_n    = 1'b0;
                                addr_n  = sp_plus1_s;
                            end
                        end
                        default: begin
                            // NOP and reserved codes are consumed without effect.
                            state_n = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    state_n     = ST_DONE;
                    req_n       = 1'b0;
                    we_n        = 1'b0;
                    push_done_s = (op_r == OP_PUSH);
                    pop_done_s  = (op_r == OP_POP);
                    if (is_load_op(op_r)) begin
                        res_valid_n = 1'b1;
                        res_data_n  = mem_rdata;
                    end else begin
                        res_valid_n = 1'b0;
                    end
                end else begin
                    state_n = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                req_n   = 1'b0;
                we_n    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops an open request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_NOP;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            res_valid_r <= 1'b0;
            res_data_r  <= {DATA_W{1'b0}};
            exc_r       <= 1'b0;
        end else begin
            state_r     <= state_n;
            op_r        <= op_n;
            req_r       <= req_n;
            we_r        <= we_n;
            addr_r      <= addr_n;
            wdata_r     <= wdata_n;
            res_valid_r <= res_valid_n;
            res_data_r  <= res_data_n;
            exc_r       <= exc_n;
        end
    end

    assign op_ready  = (state_r == ST_IDLE);
    assign mem_req   = req_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign sp        = sp_s;
    assign stack_exc = exc_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (default or STACK_CHECK_EN build).
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [10:0] op_addr;
    logic [15:0] op_data;
    logic        mem_req;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        res_valid;
    logic [15:0] res_data;
    logic [10:0] sp;
    logic        stack_exc;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_addr   (op_addr),
        .op_data   (op_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .res_valid (res_valid),
        .res_data  (res_data),
        .sp        (sp),
        .stack_exc (stack_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] code, input logic [10:0] addr, input logic [15:0] data);
        op_valid = 1'b1;
        op_code  = code;
        op_addr  = addr;
        op_data  = data;
        tick();
        op_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_addr = 11'h000;
        op_data = 16'h0000; mem_rdata = 16'h0000; mem_ack = 1'b0;
        tick(); tick();
        chk("rst_op_ready", op_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_sp", sp, 11'h7FF);
        chk("rst_stack_exc", stack_exc, 0);
        rst = 1'b0;
        tick();

        // NOP and reserved code: stay in IDLE, nothing driven
        issue(3'd0, 11'h123, 16'h5555);
        chk("nop_ready", op_ready, 1);
        chk("nop_req", mem_req, 0);
        issue(3'd7, 11'h123, 16'h5555);
        chk("rsv_ready", op_ready, 1);
        chk("rsv_req", mem_req, 0);
        chk("rsv_res_valid", res_valid, 0);

        // 1: LDM immediate
        issue(3'd1, 11'h000, 16'hBEEF);
        chk("ldm_res_valid", res_valid, 1);
        chk("ldm_res_data", res_data, 16'hBEEF);
        chk("ldm_req", mem_req, 0);
        chk("ldm_ready", op_ready, 0);
        tick();
        chk("ldm_res_valid_drop", res_valid, 0);
        chk("ldm_ready_back", op_ready, 1);
        chk("ldm_req_after", mem_req, 0);

        // 2: STD with ack in the third access cycle
        issue(3'd3, 11'h010, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            chk("std_req", mem_req, 1);
            chk("std_we", mem_we, 1);
            chk("std_addr", mem_addr, 11'h010);
            chk("std_wdata", mem_wdata, 16'h1234);
            chk("std_ready", op_ready, 0);
            if (i == 2) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        chk("std_req_drop", mem_req, 0);
        chk("std_res_valid", res_valid, 0);
        chk("std_done_ready", op_ready, 0);
        tick();
        chk("std_ready_back", op_ready, 1);

        // ack outside ACCESS is ignored
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        chk("stray_ack_res_valid", res_valid, 0);
        chk("stray_ack_sp", sp, 11'h7FF);
        chk("stray_ack_ready", op_ready, 1);

        // 3: PUSH then POP with immediate ack
        issue(3'd4, 11'h000, 16'hAAAA);
        chk("push_req", mem_req, 1);
        chk("push_we", mem_we, 1);
        chk("push_addr", mem_addr, 11'h7FF);
        chk("push_wdata", mem_wdata, 16'hAAAA);
        chk("push_sp_before", sp, 11'h7FF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("push_sp_after", sp, 11'h7FE);
        chk("push_req_drop", mem_req, 0);
        chk("push_res_valid", res_valid, 0);
        tick();
        issue(3'd5, 11'h000, 16'h0000);
        chk("pop_req", mem_req, 1);
        chk("pop_we", mem_we, 0);
        chk("pop_addr", mem_addr, 11'h7FF);
        chk("pop_sp_before", sp, 11'h7FE);
        mem_ack = 1'b1; mem_rdata = 16'hAAAA;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("pop_res_valid", res_valid, 1);
        chk("pop_res_data", res_data, 16'hAAAA);
        chk("pop_sp_after", sp, 11'h7FF);
        tick();
        chk("pop_res_valid_drop", res_valid, 0);

        // 4: LDD, ack in first access cycle -> result two cycles after accept
        issue(3'd2, 11'h005, 16'h0000);
        chk("ldd_req", mem_req, 1);
        chk("ldd_we", mem_we, 0);
        chk("ldd_addr", mem_addr, 11'h005);
        chk("ldd_res_valid_early", res_valid, 0);
        mem_ack = 1'b1; mem_rdata = 16'h00C3;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("ldd_res_valid", res_valid, 1);
        chk("ldd_res_data", res_data, 16'h00C3);
        chk("ldd_sp", sp, 11'h7FF);
        tick();

        // 5: reset in the middle of a PUSH (sp first moved away from its reset value)
        issue(3'd4, 11'h000, 16'h1111);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("pre_rst_sp", sp, 11'h7FE);
        issue(3'd4, 11'h000, 16'h2222);
        chk("mid_push_req", mem_req, 1);
        chk("mid_push_addr", mem_addr, 11'h7FE);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_sp", sp, 11'h7FF);
        chk("rst_mid_ready", op_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_req", mem_req, 0);

        // 6: POP on an empty stack
        issue(3'd5, 11'h000, 16'h0000);
`ifdef STACK_CHECK_EN
        chk("pop_empty_exc", stack_exc, 1);
        chk("pop_empty_req", mem_req, 0);
        chk("pop_empty_res_valid", res_valid, 0);
        chk("pop_empty_sp", sp, 11'h7FF);
        tick();
        chk("pop_empty_exc_drop", stack_exc, 0);
        chk("pop_empty_ready", op_ready, 1);
        chk("pop_empty_sp_kept", sp, 11'h7FF);
`else
        chk("pop_wrap_exc", stack_exc, 0);
        chk("pop_wrap_req", mem_req, 1);
        chk("pop_wrap_addr", mem_addr, 11'h000);
        mem_ack = 1'b1; mem_rdata = 16'h0F0F;
        tick();
        mem_ack = 1'b0;
        chk("pop_wrap_sp", sp, 11'h000);
        chk("pop_wrap_res", res_data, 16'h0F0F);
        tick();
        // PUSH at sp==0 wraps back to the top
        issue(3'd4, 11'h000, 16'h7777);
        chk("push_wrap_addr", mem_addr, 11'h000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("push_wrap_sp", sp, 11'h7FF);
        chk("push_wrap_exc", stack_exc, 0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
